// File: rtl/ysyx_220066_pkg.sv
// Shared RV64 EX-stage constants, M-unit op codes and the EX->MEM buffer entry.
package ysyx_220066_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [XLEN-1:0] MIN_INT64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HALF_W-1:0] MIN_INT32 = {1'b1, {(HALF_W-1){1'b0}}};

  localparam logic [OP_W-1:0] MD_DIV  = 3'b100;
  localparam logic [OP_W-1:0] MD_DIVU = 3'b101;
  localparam logic [OP_W-1:0] MD_REM  = 3'b110;
  localparam logic [OP_W-1:0] MD_REMU = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic [XLEN-1:0]   result;
    logic              trap;
  } exbuf_entry_t;

  // Sign-extend the low word of a W-variant result to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [HALF_W-1:0] v);
    return {{(XLEN-HALF_W){v[HALF_W-1]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_220066_divfix.sv
// Result select between ALU and M-unit, with the RISC-V divide-by-zero and
// signed-overflow results substituted for the raw divider output.
module ysyx_220066_divfix
  import ysyx_220066_pkg::*;
(
  input  logic            is_mul,
  input  logic [OP_W-1:0] aluctr,
  input  logic            is_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] mul_res,
  output logic [XLEN-1:0] result_c
);

  logic is_div_family;
  logic is_rem;
  logic is_signed;
  logic div_zero;
  logic overflow;

  // aluctr[1] picks rem over div, aluctr[0] picks unsigned.
  always_comb begin
    is_div_family = aluctr[2];
    is_rem        = aluctr[1];
    is_signed     = ~aluctr[0];
    div_zero      = is_w ? (src2[HALF_W-1:0] == '0) : (src2 == '0);
    overflow      = is_signed &&
                    (is_w ? ((src1[HALF_W-1:0] == MIN_INT32) && (src2[HALF_W-1:0] == '1))
                          : ((src1 == MIN_INT64) && (src2 == '1)));

    result_c = mul_res;
    if (!is_mul) begin
      result_c = alu_res;
    end else if (is_div_family) begin
      if (div_zero) begin
        if (is_rem) begin
          result_c = is_w ? sext32(src1[HALF_W-1:0]) : src1;
        end else begin
          result_c = '1;
        end
      end else if (overflow) begin
        if (is_rem) begin
          result_c = '0;
        end else begin
          result_c = is_w ? sext32(MIN_INT32) : MIN_INT64;
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_220066_ex_mem_buf.sv
// Two-entry EX->MEM buffer holding already fixed-up results behind a valid/ready
// handshake. Define YSYX_220066_DIVZERO_TRAP_EN to store and present out_trap.
module ysyx_220066_ex_mem_buf
  import ysyx_220066_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_is_mul,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_mul_res,
  input  logic              in_mul_err,
  input  logic [OP_W-1:0]   in_aluctr,
  input  logic              in_is_w,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_result,
  output logic              out_trap
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  exbuf_entry_t     mem [DEPTH];
  logic             wptr;
  logic             rptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  fixed_result;
  exbuf_entry_t     new_entry;

  ysyx_220066_divfix u_divfix (
    .is_mul   (in_is_mul),
    .aluctr   (in_aluctr),
    .is_w     (in_is_w),
    .src1     (in_src1),
    .src2     (in_src2),
    .alu_res  (in_alu_res),
    .mul_res  (in_mul_res),
    .result_c (fixed_result)
  );

  // Handshake flags decode the registered count only.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry        = '0;
    new_entry.pc     = in_pc;
    new_entry.rd     = in_rd;
    new_entry.wen    = in_wen;
    new_entry.result = fixed_result;
`ifdef YSYX_220066_DIVZERO_TRAP_EN
    new_entry.trap   = in_mul_err && in_is_mul && in_aluctr[2];
`endif
  end

  // Flush drops state but leaves stale storage behind out_valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= new_entry;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_pc     = mem[rptr].pc;
  assign out_rd     = mem[rptr].rd;
  assign out_wen    = mem[rptr].wen;
  assign out_result = mem[rptr].result;

`ifdef YSYX_220066_DIVZERO_TRAP_EN
  assign out_trap = mem[rptr].trap;
`else
  assign out_trap = 1'b0;
  logic unused_trap;
  assign unused_trap = ^{in_mul_err, mem[0].trap, mem[1].trap};
`endif

endmodule

// File: tb/tb_ysyx_220066_ex_mem_buf.sv
// Scoreboard bench for ysyx_220066_ex_mem_buf: accepted pushes queue their
// expected entry, pops are compared against the queue head.
module tb_ysyx_220066_ex_mem_buf;
  import ysyx_220066_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_wen, in_is_mul, in_mul_err, in_is_w;
  logic [63:0] in_pc, in_alu_res, in_mul_res, in_src1, in_src2;
  logic [4:0]  in_rd;
  logic [2:0]  in_aluctr;
  logic        out_valid, out_ready, out_wen, out_trap;
  logic [63:0] out_pc, out_result;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  ysyx_220066_ex_mem_buf dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd), .in_wen(in_wen),
    .in_is_mul(in_is_mul), .in_alu_res(in_alu_res), .in_mul_res(in_mul_res),
    .in_mul_err(in_mul_err), .in_aluctr(in_aluctr), .in_is_w(in_is_w),
    .in_src1(in_src1), .in_src2(in_src2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_wen(out_wen), .out_result(out_result), .out_trap(out_trap)
  );

  int n_checks = 0;
  int n_pass   = 0;
  exbuf_entry_t exp_q[$];
  bit mon_en = 1'b0;

`ifdef YSYX_220066_DIVZERO_TRAP_EN
  localparam logic TRAP_ON = 1'b1;
`else
  localparam logic TRAP_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference result from the RISC-V M-extension rules.
  function automatic logic [63:0] model_result(input logic is_mul, input logic [2:0] op,
      input logic is_w, input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] alu, input logic [63:0] mr);
    logic [63:0] divisor;
    if (!is_mul) return alu;
    if (!op[2]) return mr;
    divisor = is_w ? {32'd0, b[31:0]} : b;
    if (divisor == 64'd0) begin
      if (op == MD_DIV || op == MD_DIVU) return 64'hFFFF_FFFF_FFFF_FFFF;
      return is_w ? {{32{a[31]}}, a[31:0]} : a;
    end
    if (op == MD_DIV || op == MD_REM) begin
      if (is_w && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        return (op == MD_DIV) ? 64'hFFFF_FFFF_8000_0000 : 64'd0;
      if (!is_w && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
        return (op == MD_DIV) ? 64'h8000_0000_0000_0000 : 64'd0;
    end
    return mr;
  endfunction

  always @(negedge clk) begin : mon
    exbuf_entry_t e;
    if (mon_en) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (!rst && !flush && out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_rd", 64'(out_rd), 64'(e.rd));
        check("out_wen", 64'(out_wen), 64'(e.wen));
        check("out_result", out_result, e.result);
        check("out_trap", 64'(out_trap), 64'(e.trap));
      end
      if (rst || flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        e.pc     = in_pc;
        e.rd     = in_rd;
        e.wen    = in_wen;
        e.result = model_result(in_is_mul, in_aluctr, in_is_w, in_src1, in_src2,
                                in_alu_res, in_mul_res);
        e.trap   = TRAP_ON && in_mul_err && in_is_mul && in_aluctr[2];
        exp_q.push_back(e);
      end
    end
  end

  task automatic push_op(input logic [63:0] pc, input logic [4:0] rd, input logic is_mul,
      input logic [2:0] op, input logic is_w, input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] alu, input logic [63:0] mr, input logic err);
    int budget = 100;
    in_valid = 1'b1; in_pc = pc; in_rd = rd; in_wen = 1'b1; in_is_mul = is_mul;
    in_aluctr = op; in_is_w = is_w; in_src1 = a; in_src2 = b;
    in_alu_res = alu; in_mul_res = mr; in_mul_err = err;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check("push_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic md(input logic [63:0] pc, input logic [2:0] op, input logic is_w,
      input logic [63:0] a, input logic [63:0] b);
    logic zero;
    zero = is_w ? (b[31:0] == 32'd0) : (b == 64'd0);
    push_op(pc, 5'd10, 1'b1, op, is_w, a, b, 64'h0, 64'h5A5A_0000_1234_5678, zero);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_rd = '0; in_wen = 1'b0; in_is_mul = 1'b0; in_alu_res = '0;
    in_mul_res = '0; in_mul_err = 1'b0; in_aluctr = '0; in_is_w = 1'b0;
    in_src1 = '0; in_src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_wen", 64'(out_wen), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_trap", 64'(out_trap), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;
    rst = 1'b0;

    // Fix-up cases, one at a time with MEM always ready.
    out_ready = 1'b1;
    md(64'h1000, MD_DIVU, 1'b0, 64'd7, 64'd0);
    check("divu0_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("divu0_trap", 64'(out_trap), 64'(TRAP_ON));
    md(64'h1004, MD_REM, 1'b1, 64'h0000_0000_8000_0005, 64'd0);
    check("remw0_result", out_result, 64'hFFFF_FFFF_8000_0005);
    md(64'h1008, MD_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div_ovf_result", out_result, 64'h8000_0000_0000_0000);
    md(64'h100C, MD_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rem_ovf_result", out_result, 64'd0);
    md(64'h1010, MD_DIV, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF);
    md(64'h1014, MD_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    md(64'h1018, MD_DIVU, 1'b1, 64'd99, 64'h0000_0001_0000_0000);
    md(64'h101C, MD_REMU, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd0);
    md(64'h1020, MD_DIVU, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    md(64'h1024, MD_DIV, 1'b0, 64'd100, 64'd7);
    md(64'h1028, 3'b001, 1'b0, 64'd3, 64'd0);
    push_op(64'h102C, 5'd3, 1'b0, MD_DIV, 1'b0, 64'd1, 64'd0, 64'hCAFE_F00D, 64'h1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two fill the buffer, the third waits for MEM.
    out_ready = 1'b0;
    push_op(64'h2000, 5'd1, 1'b0, 3'b000, 1'b0, 0, 0, 64'hA0, 0, 1'b0);
    push_op(64'h2004, 5'd2, 1'b0, 3'b000, 1'b0, 0, 0, 64'hA1, 0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_out_pc", out_pc, 64'h2000);
    check("stall_out_result", out_result, 64'hA0);
    fork
      push_op(64'h2008, 5'd3, 1'b0, 3'b000, 1'b0, 0, 0, 64'hA2, 0, 1'b0);
      out_ready = 1'b1;
    join
    repeat (3) @(posedge clk);
    #1;

    // Flush with a full buffer and a concurrent push.
    out_ready = 1'b0;
    push_op(64'h3000, 5'd4, 1'b0, 3'b000, 1'b0, 0, 0, 64'hB0, 0, 1'b0);
    push_op(64'h3004, 5'd5, 1'b0, 3'b000, 1'b0, 0, 0, 64'hB1, 0, 1'b0);
    in_valid = 1'b1; in_pc = 64'h3008; in_alu_res = 64'hBAD; in_is_mul = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_flush_out_valid", 64'(out_valid), 64'd0);

    // Back-to-back ALU stream.
    for (int i = 0; i < 16; i++) begin
      push_op(64'h4000 + 64'(4 * i), 5'(i), 1'b0, 3'b000, 1'b0, 0, 0,
              64'h1111_0000 + 64'(i * 7), 0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of buffered traffic.
    out_ready = 1'b0;
    push_op(64'h5000, 5'd6, 1'b0, 3'b000, 1'b0, 0, 0, 64'hC0, 0, 1'b0);
    push_op(64'h5004, 5'd7, 1'b0, 3'b000, 1'b0, 0, 0, 64'hC1, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_pc", out_pc, 64'd0);
    check("midrst_out_result", out_result, 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    push_op(64'h6000, 5'd8, 1'b0, 3'b000, 1'b0, 0, 0, 64'hD0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_ex_mem_buf.md
# ysyx_220066_ex_mem_buf

Two-entry EX→MEM buffer for the RV64 core. It sits directly downstream of the EX-stage ALU and the multiply/divide unit and captures one result per instruction. It applies the RISC-V-mandated divide-by-zero and signed-overflow result fix-ups, because the divide unit only flags these cases and does not correct them. It then presents the buffered results to MEM over a valid/ready handshake.

## Interface
- No parameters; widths are fixed for RV64.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush (branch mispredict or trap); empties the buffer.
- `in_valid` in 1: EX presents an instruction.
- `in_ready` out 1: buffer can accept an instruction.
- `in_pc` in 64: instruction PC.
- `in_rd` in 5: destination register.
- `in_wen` in 1: register write enable.
- `in_is_mul` in 1: 1 selects the M-unit result, 0 selects the ALU result.
- `in_alu_res` in 64: ALU result.
- `in_mul_res` in 64: M-unit result.
- `in_mul_err` in 1: M-unit divide-by-zero flag.
- `in_aluctr` in 3: M-unit op code. 100=div, 101=divu, 110=rem, 111=remu, 0xx=mul family.
- `in_is_w` in 1: 32-bit (W) variant.
- `in_src1` in 64: M-unit operand 1.
- `in_src2` in 64: M-unit operand 2.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: MEM accepts the head entry.
- `out_pc` out 64: PC of the head entry.
- `out_rd` out 5: destination register of the head entry.
- `out_wen` out 1: write enable of the head entry.
- `out_result` out 64: final fixed-up result.
- `out_trap` out 1: divide-by-zero trap marker; see Configuration.

## Operation
- Storage is a 2-entry FIFO with 1-bit read and write pointers and a 2-bit count (0..2).
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != 2)`. It is a function of state only; there is no combinational path from `out_ready`.
- `out_valid = (count != 0)`. The head entry drives all `out_*` signals.
- Result selection and fix-up are computed at push time and stored already corrected:
  - `in_is_mul=0`: result = `in_alu_res`.
  - mul family (`aluctr[2]=0`): result = `in_mul_res`.
  - Divide by zero, where the divisor is `src2` (or `src2[31:0]` when W) and equals 0:
    - div/divu: result = 64'hFFFF_FFFF_FFFF_FFFF.
    - rem/remu: result = `src1`; when W, result = `src1[31:0]` sign-extended.
  - Signed overflow on div/rem only:
    - Non-W condition: `src1`=64'h8000_0000_0000_0000 and `src2`=all ones.
    - W condition: `src1[31:0]`=32'h8000_0000 and `src2[31:0]`=32'hFFFF_FFFF.
    - div result = most-negative value (sign-extended when W). rem result = 0.
  - Otherwise: result = `in_mul_res`.
- Simultaneous push and pop: allowed when count is 1, and count stays 1. At count 2 a push cannot occur because `in_ready=0`. At count 0 a pop cannot occur.
- Pointers wrap modulo 2.

## Timing
- Latency is 1 cycle: an entry pushed at edge N is visible at `out_*` with `out_valid=1` after edge N.
- Throughput is 1 instruction per cycle while `out_ready` stays high.
- Reset (`rst=1` at an edge):
  - count, pointers, and all entry storage clear to 0.
  - Outputs after the edge: `out_valid=0`, `out_pc=0`, `out_rd=0`, `out_wen=0`, `out_result=0`, `out_trap=0`, `in_ready=1`.
- Pushes and pops are ignored in any cycle where `rst=1`.
- Flush (`flush=1` at an edge): count and pointers clear, as for reset. A push presented in the same cycle is dropped, and any pop in that cycle is irrelevant.
- Reset asserted in the middle of a stream discards all buffered entries, with no partial state left behind.
- `out_*` remain stable while `out_valid && !out_ready`.

## Configuration
- `YSYX_220066_DIVZERO_TRAP_EN` defined:
  - `out_trap` = stored `in_mul_err && in_is_mul && in_aluctr[2]`, captured at push.
  - Used by the simulation environment to halt on divide-by-zero.
  - `out_result` is still the fixed-up value.
- Not defined: `out_trap` is tied to 0 and no trap bit is stored.

## Structure
- Shared package `ysyx_220066_pkg` holds:
  - Op-code constants `MD_DIV`, `MD_DIVU`, `MD_REM`, `MD_REMU`.
  - Constants `XLEN=64` and `MIN_INT64`.
  - Packed struct `exbuf_entry_t` with fields pc, rd, wen, result, and trap.
- Sub-module `ysyx_220066_divfix`: purely combinational select-and-fix-up logic (inputs `is_mul`, `aluctr`, `is_w`, `src1`, `src2`, `alu_res`, `mul_res`; output the final result).
- The top level holds the FIFO storage, pointers, and handshake logic.

## Test plan
- After reset, push `divu` with `src1`=7, `src2`=0, `is_w`=0 → `out_result`=FFFF_FFFF_FFFF_FFFF one cycle later. `out_trap`=1 with the macro defined, 0 without.
- `remw` with `src1`=64'h0000_0000_8000_0005, `src2`=0 → `out_result`=FFFF_FFFF_8000_0005.
- `div` with `src1`=8000_0000_0000_0000, `src2`=FFFF_FFFF_FFFF_FFFF → result 8000_0000_0000_0000. `rem` on the same operands → result 0.
- Hold `out_ready=0` and push 3 back-to-back instructions → `in_ready` drops after the 2nd push. Raise `out_ready` → both entries pop in order and the 3rd is then accepted.
- With count=2, assert `flush` together with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, and nothing from the flush cycle appears.
- Continuous stream of 16 ALU results with `out_ready=1` → one result out per cycle, in order, 1-cycle latency, with count staying at 1.
